// File: rtl/pipe_control_unit.sv
// LEGv8 five-stage pipeline control: decode, ID/EX, EX/MEM and MEM/WB control registers, hazard stall and EX forwarding.
// Define FORWARDING_EN for forwarding with load-use stalls; without it every RAW hazard stalls until write-back completes.
module pipe_control_unit #(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instr_id,
    input  logic              id_valid,
    input  logic              branch_taken,
    output logic              stall,
    output logic [2:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_flag_write,
    output logic              ex_take_branch,
    output logic              ex_reg_branch,
    output logic [1:0]        ex_cond,
    output logic              ex_reg2loc,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    localparam logic [REG_AW-1:0] XZR     = REG_AW'(ZERO_REG);
    localparam logic [REG_AW-1:0] LINK_RG = REG_AW'(30);

    localparam logic [10:0] OP_ADDS = 11'h558;
    localparam logic [10:0] OP_SUBS = 11'h758;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [10:0] OP_BR   = 11'h6B0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;
    localparam logic [7:0]  OP_BC   = 8'h54;
    localparam logic [4:0]  COND_LT = 5'b01011;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [5:0]  OP_BL   = 6'b100101;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [1:0] CND_UNC = 2'b00;
    localparam logic [1:0] CND_CBZ = 2'b01;
    localparam logic [1:0] CND_LT  = 2'b10;

    typedef struct packed {
        logic [2:0]        alu_op;
        logic              alu_src;
        logic              flag_write;
        logic              take_branch;
        logic              reg_branch;
        logic [1:0]        cond;
        logic              reg2loc;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
        logic              src1_v;
        logic [REG_AW-1:0] src1;
        logic              src2_v;
        logic [REG_AW-1:0] src2;
    } idex_t;

    typedef struct packed {
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } exmem_t;

    typedef struct packed {
        logic              reg_write;
        logic              mem_to_reg;
        logic [REG_AW-1:0] rd;
    } memwb_t;

    idex_t  dec_c, idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;
    logic   ex_valid_q, ex_valid_d;
    logic   mem_valid_q, mem_valid_d;
    logic   wb_valid_q, wb_valid_d;
    logic   hazard_c, accept_c;
    logic   ex_dst_v_c, mem_dst_v_c, wb_dst_v_c;
    logic   unused_c;

    logic [REG_AW-1:0] rd_f, rn_f, rm_f;
    assign rd_f = REG_AW'(instr_id[4:0]);
    assign rn_f = REG_AW'(instr_id[9:5]);
    assign rm_f = REG_AW'(instr_id[20:16]);

    // Source/destination match; XZR never creates a dependency.
    function automatic logic reg_hit(input logic s_v, input logic [REG_AW-1:0] s,
                                     input logic d_v, input logic [REG_AW-1:0] d);
        return s_v && d_v && (s == d) && (s != XZR);
    endfunction

    // Instruction decode; unrecognised encodings leave every control at zero.
    always_comb begin
        dec_c = '0;
        if (instr_id[31:21] == OP_ADDS || instr_id[31:21] == OP_SUBS) begin
            dec_c.alu_op     = (instr_id[31:21] == OP_SUBS) ? ALU_SUB : ALU_ADD;
            dec_c.flag_write = 1'b1;
            dec_c.reg_write  = 1'b1;
            dec_c.rd         = rd_f;
            dec_c.src1_v     = 1'b1;
            dec_c.src1       = rn_f;
            dec_c.src2_v     = 1'b1;
            dec_c.src2       = rm_f;
        end else if (instr_id[31:22] == OP_ADDI) begin
            dec_c.alu_op    = ALU_ADD;
            dec_c.alu_src   = 1'b1;
            dec_c.reg_write = 1'b1;
            dec_c.rd        = rd_f;
            dec_c.src1_v    = 1'b1;
            dec_c.src1      = rn_f;
        end else if (instr_id[31:21] == OP_LDUR) begin
            dec_c.alu_op     = ALU_ADD;
            dec_c.alu_src    = 1'b1;
            dec_c.mem_read   = 1'b1;
            dec_c.reg_write  = 1'b1;
            dec_c.mem_to_reg = 1'b1;
            dec_c.rd         = rd_f;
            dec_c.src1_v     = 1'b1;
            dec_c.src1       = rn_f;
        end else if (instr_id[31:21] == OP_STUR) begin
            dec_c.alu_op    = ALU_ADD;
            dec_c.alu_src   = 1'b1;
            dec_c.mem_write = 1'b1;
            dec_c.reg2loc   = 1'b1;
            dec_c.src1_v    = 1'b1;
            dec_c.src1      = rn_f;
            dec_c.src2_v    = 1'b1;
            dec_c.src2      = rd_f;
        end else if (instr_id[31:21] == OP_BR) begin
            dec_c.take_branch = 1'b1;
            dec_c.reg_branch  = 1'b1;
            dec_c.cond        = CND_UNC;
            dec_c.src1_v      = 1'b1;
            dec_c.src1        = rn_f;
        end else if (instr_id[31:24] == OP_CBZ) begin
            dec_c.take_branch = 1'b1;
            dec_c.cond        = CND_CBZ;
            dec_c.reg2loc     = 1'b1;
            dec_c.src2_v      = 1'b1;
            dec_c.src2        = rd_f;
        end else if (instr_id[31:24] == OP_BC && instr_id[4:0] == COND_LT) begin
            dec_c.take_branch = 1'b1;
            dec_c.cond        = CND_LT;
        end else if (instr_id[31:26] == OP_B) begin
            dec_c.take_branch = 1'b1;
            dec_c.cond        = CND_UNC;
        end else if (instr_id[31:26] == OP_BL) begin
            dec_c.take_branch = 1'b1;
            dec_c.cond        = CND_UNC;
            dec_c.reg_write   = 1'b1;
            dec_c.rd          = LINK_RG;
        end
    end

    assign ex_dst_v_c  = ex_valid_q  && idex_q.reg_write;
    assign mem_dst_v_c = mem_valid_q && exmem_q.reg_write;
    assign wb_dst_v_c  = wb_valid_q  && memwb_q.reg_write;

`ifdef FORWARDING_EN
    // Only a load in EX cannot be forwarded in time.
    assign hazard_c = id_valid && idex_q.mem_read && ex_valid_q &&
                      (reg_hit(dec_c.src1_v, dec_c.src1, ex_dst_v_c, idex_q.rd) ||
                       reg_hit(dec_c.src2_v, dec_c.src2, ex_dst_v_c, idex_q.rd));

    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (reg_hit(ex_valid_q && idex_q.src1_v, idex_q.src1, mem_dst_v_c, exmem_q.rd)) begin
            fwd_a = 2'b01;
        end else if (reg_hit(ex_valid_q && idex_q.src1_v, idex_q.src1, wb_dst_v_c, memwb_q.rd)) begin
            fwd_a = 2'b10;
        end
        if (reg_hit(ex_valid_q && idex_q.src2_v, idex_q.src2, mem_dst_v_c, exmem_q.rd)) begin
            fwd_b = 2'b01;
        end else if (reg_hit(ex_valid_q && idex_q.src2_v, idex_q.src2, wb_dst_v_c, memwb_q.rd)) begin
            fwd_b = 2'b10;
        end
    end

    assign unused_c = ^instr_id[15:10];
`else
    // Without bypass paths the reader waits until the writer has left WB.
    assign hazard_c = id_valid &&
                      (reg_hit(dec_c.src1_v, dec_c.src1, ex_dst_v_c,  idex_q.rd)  ||
                       reg_hit(dec_c.src2_v, dec_c.src2, ex_dst_v_c,  idex_q.rd)  ||
                       reg_hit(dec_c.src1_v, dec_c.src1, mem_dst_v_c, exmem_q.rd) ||
                       reg_hit(dec_c.src2_v, dec_c.src2, mem_dst_v_c, exmem_q.rd) ||
                       reg_hit(dec_c.src1_v, dec_c.src1, wb_dst_v_c,  memwb_q.rd) ||
                       reg_hit(dec_c.src2_v, dec_c.src2, wb_dst_v_c,  memwb_q.rd));

    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;

    assign unused_c = ^{instr_id[15:10], idex_q.src1_v, idex_q.src1, idex_q.src2_v, idex_q.src2};
`endif

    // A taken branch squashes the ID instruction, which also cancels its stall.
    assign stall    = hazard_c && !branch_taken;
    assign accept_c = id_valid && !branch_taken && !hazard_c;

    always_comb begin
        ex_valid_d          = accept_c;
        idex_d              = accept_c ? dec_c : '0;
        mem_valid_d         = ex_valid_q;
        exmem_d             = '0;
        wb_valid_d          = mem_valid_q;
        memwb_d             = '0;
        if (ex_valid_q) begin
            exmem_d.mem_read   = idex_q.mem_read;
            exmem_d.mem_write  = idex_q.mem_write;
            exmem_d.reg_write  = idex_q.reg_write;
            exmem_d.mem_to_reg = idex_q.mem_to_reg;
            exmem_d.rd         = idex_q.rd;
        end
        if (mem_valid_q) begin
            memwb_d.reg_write  = exmem_q.reg_write;
            memwb_d.mem_to_reg = exmem_q.mem_to_reg;
            memwb_d.rd         = exmem_q.rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            mem_valid_q <= mem_valid_d;
            wb_valid_q  <= wb_valid_d;
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
        end
    end

    assign ex_alu_op      = ex_valid_q  ? idex_q.alu_op      : 3'b000;
    assign ex_alu_src     = ex_valid_q  && idex_q.alu_src;
    assign ex_flag_write  = ex_valid_q  && idex_q.flag_write;
    assign ex_take_branch = ex_valid_q  && idex_q.take_branch;
    assign ex_reg_branch  = ex_valid_q  && idex_q.reg_branch;
    assign ex_cond        = ex_valid_q  ? idex_q.cond        : 2'b00;
    assign ex_reg2loc     = ex_valid_q  && idex_q.reg2loc;
    assign mem_read       = mem_valid_q && exmem_q.mem_read;
    assign mem_write      = mem_valid_q && exmem_q.mem_write;
    assign wb_reg_write   = wb_valid_q  && memwb_q.reg_write;
    assign wb_mem_to_reg  = wb_valid_q  && memwb_q.mem_to_reg;
    assign wb_rd          = wb_valid_q  ? memwb_q.rd         : '0;

endmodule

// File: tb/tb_pipe_control_unit.sv
// Scoreboard bench for pipe_control_unit: an instruction-level pipeline model predicts every output each cycle.
module tb_pipe_control_unit;

    typedef enum logic [3:0] {
        K_NOP, K_ADDS, K_SUBS, K_ADDI, K_LDUR, K_STUR, K_BR, K_CBZ, K_BLT, K_B, K_BL
    } kind_e;

    typedef struct {
        bit          v;
        kind_e       kind;
        int          rd;
        int          rn;
        int          rm;
        logic [31:0] imm;
        bit          bt;
        bit          rst;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_id;
    logic        id_valid;
    logic        branch_taken;
    logic        stall;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src, ex_flag_write, ex_take_branch, ex_reg_branch, ex_reg2loc;
    logic [1:0]  ex_cond;
    logic        mem_read, mem_write, wb_reg_write, wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic [1:0]  fwd_a, fwd_b;

    pipe_control_unit dut (
        .clk(clk), .reset(reset), .instr_id(instr_id), .id_valid(id_valid),
        .branch_taken(branch_taken), .stall(stall), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_flag_write(ex_flag_write),
        .ex_take_branch(ex_take_branch), .ex_reg_branch(ex_reg_branch),
        .ex_cond(ex_cond), .ex_reg2loc(ex_reg2loc), .mem_read(mem_read),
        .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    always #5 clk = ~clk;

    logic [23:0] exp_q[$];
    rec_t        dir_q[$];
    rec_t        ex_r, mem_r, wb_r;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;

    function automatic rec_t bubble();
        rec_t r;
        r.v = 1'b0; r.kind = K_NOP; r.rd = 0; r.rn = 0; r.rm = 0;
        r.imm = '0; r.bt = 1'b0; r.rst = 1'b0;
        return r;
    endfunction

    function automatic rec_t mk(kind_e k, int d, int n, int m);
        rec_t r;
        r = bubble();
        r.v = 1'b1; r.kind = k; r.rd = d; r.rn = n; r.rm = m; r.imm = $urandom;
        return r;
    endfunction

    function automatic int rand_reg();
        case ($urandom_range(0, 4))
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 30;
            default: return 31;
        endcase
    endfunction

    function automatic rec_t rand_rec();
        rec_t r;
        r = mk(kind_e'(4'($urandom_range(0, 10))), rand_reg(), rand_reg(), rand_reg());
        r.v  = ($urandom_range(0, 9) != 0);
        r.bt = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    function automatic logic [31:0] encode(rec_t r);
        logic [31:0] im;
        logic [4:0]  d, n, m;
        im = r.imm; d = 5'(r.rd); n = 5'(r.rn); m = 5'(r.rm);
        case (r.kind)
            K_ADDS:  return {11'h558, m, im[5:0], n, d};
            K_SUBS:  return {11'h758, m, im[5:0], n, d};
            K_ADDI:  return {10'h244, im[11:0], n, d};
            K_LDUR:  return {11'h7C2, im[8:0], 2'b00, n, d};
            K_STUR:  return {11'h7C0, im[8:0], 2'b00, n, d};
            K_BR:    return {11'h6B0, 5'h1F, 6'h00, n, 5'h00};
            K_CBZ:   return {8'hB4, im[18:0], d};
            K_BLT:   return {8'h54, im[18:0], 5'b01011};
            K_B:     return {6'b000101, im[25:0]};
            K_BL:    return {6'b100101, im[25:0]};
            default: begin
                // Encodings that must decode as nothing: zero word, B.EQ, CBNZ, all-ones.
                case (im[1:0])
                    2'd0:    return 32'h0000_0000;
                    2'd1:    return {8'h54, im[20:2], 5'b00000};
                    2'd2:    return {8'hB5, im[20:2], d};
                    default: return 32'hFFFF_FFFF;
                endcase
            end
        endcase
    endfunction

    // {alu_op, alu_src, flag_write, take_branch, reg_branch, cond, reg2loc}
    function automatic logic [9:0] ex_ctl(kind_e k);
        case (k)
            K_ADDS:  return {3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
            K_SUBS:  return {3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
            K_ADDI:  return {3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
            K_LDUR:  return {3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
            K_STUR:  return {3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1};
            K_BR:    return {3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0};
            K_CBZ:   return {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1};
            K_BLT:   return {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0};
            K_B:     return {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
            K_BL:    return {3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
            default: return 10'd0;
        endcase
    endfunction

    function automatic bit writes(rec_t r);
        return r.v && (r.kind inside {K_ADDS, K_SUBS, K_ADDI, K_LDUR, K_BL});
    endfunction

    function automatic int raw_rd(rec_t r);
        if (!writes(r)) return 0;
        return (r.kind == K_BL) ? 30 : r.rd;
    endfunction

    // Dependency-visible register numbers; -1 means none (XZR included).
    function automatic int dst_of(rec_t r);
        if (!writes(r) || raw_rd(r) == 31) return -1;
        return raw_rd(r);
    endfunction

    function automatic int s1_of(rec_t r);
        if (!r.v || !(r.kind inside {K_ADDS, K_SUBS, K_ADDI, K_LDUR, K_STUR, K_BR}) || r.rn == 31) return -1;
        return r.rn;
    endfunction

    function automatic int s2_of(rec_t r);
        int s;
        s = -1;
        if (r.v && r.kind inside {K_ADDS, K_SUBS}) s = r.rm;
        if (r.v && r.kind inside {K_STUR, K_CBZ})  s = r.rd;
        return (s == 31) ? -1 : s;
    endfunction

    function automatic bit reads(rec_t r, int d);
        return d >= 0 && (s1_of(r) == d || s2_of(r) == d);
    endfunction

    function automatic logic [1:0] fwd_of(int s);
`ifdef FORWARDING_EN
        if (s >= 0 && dst_of(mem_r) == s) return 2'b01;
        if (s >= 0 && dst_of(wb_r) == s)  return 2'b10;
`endif
        return (s < -1) ? 2'b11 : 2'b00;
    endfunction

    function automatic bit hazard(rec_t id);
`ifdef FORWARDING_EN
        return id.v && ex_r.v && ex_r.kind == K_LDUR && reads(id, dst_of(ex_r));
`else
        return id.v && (reads(id, dst_of(ex_r)) || reads(id, dst_of(mem_r)) || reads(id, dst_of(wb_r)));
`endif
    endfunction

    // One clock: drive inputs, queue the predicted outputs, then advance the model.
    task automatic cycle(input rec_t id, input bit rst, output bit stl);
        bit hz;
        logic [23:0] e;
        instr_id     = encode(id);
        id_valid     = id.v;
        branch_taken = id.bt;
        reset        = rst;
        hz  = hazard(id);
        stl = hz && !id.bt;
        e = {stl, fwd_of(s1_of(ex_r)), fwd_of(s2_of(ex_r)),
             ex_r.v ? ex_ctl(ex_r.kind) : 10'd0,
             mem_r.v && mem_r.kind == K_LDUR, mem_r.v && mem_r.kind == K_STUR,
             writes(wb_r), wb_r.v && wb_r.kind == K_LDUR, 5'(raw_rd(wb_r))};
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (rst) begin
            ex_r = bubble(); mem_r = bubble(); wb_r = bubble();
        end else begin
            wb_r  = mem_r;
            mem_r = ex_r;
            ex_r  = (id.v && !id.bt && !hz) ? id : bubble();
        end
    endtask

    function automatic rec_t next_rec();
        if (dir_q.size() != 0) return dir_q.pop_front();
        return rand_rec();
    endfunction

    // Monitor: compare DUT outputs with the oldest queued prediction.
    initial begin
        logic [23:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {stall, fwd_a, fwd_b, ex_alu_op, ex_alu_src, ex_flag_write, ex_take_branch,
                     ex_reg_branch, ex_cond, ex_reg2loc, mem_read, mem_write,
                     wb_reg_write, wb_mem_to_reg, wb_rd};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got %06h expected %06h (stall,fwd_a,fwd_b,ex,mem,wb)",
                             cyc, a, e);
                end
                cyc++;
            end
        end
    end

    initial begin
        rec_t r, cur;
        bit   stl, rst;
        reset = 1'b1; id_valid = 1'b0; branch_taken = 1'b0; instr_id = '0;
        ex_r = bubble(); mem_r = bubble(); wb_r = bubble();
        repeat (2) @(posedge clk);
        #1;

        // Load-use, back-to-back ALU dependency, branch flush over hazard, BL and XZR, reset mid-stall, NOP.
        dir_q.push_back(mk(K_LDUR, 1, 2, 0));
        dir_q.push_back(mk(K_ADDS, 3, 1, 4));
        dir_q.push_back(bubble());
        dir_q.push_back(mk(K_ADDS, 1, 2, 3));
        dir_q.push_back(mk(K_SUBS, 4, 1, 1));
        dir_q.push_back(mk(K_LDUR, 1, 2, 0));
        dir_q.push_back(mk(K_CBZ, 5, 0, 0));
        r = mk(K_ADDS, 3, 1, 4); r.bt = 1'b1; dir_q.push_back(r);
        dir_q.push_back(mk(K_ADDI, 6, 7, 0));
        dir_q.push_back(mk(K_BL, 0, 0, 0));
        dir_q.push_back(mk(K_ADDS, 31, 1, 2));
        dir_q.push_back(mk(K_ADDS, 5, 31, 31));
        dir_q.push_back(mk(K_STUR, 31, 31, 0));
        dir_q.push_back(mk(K_LDUR, 1, 2, 0));
        r = mk(K_ADDS, 3, 1, 4); r.rst = 1'b1; dir_q.push_back(r);
        r = mk(K_NOP, 0, 0, 0); r.imm = '0; dir_q.push_back(r);
        dir_q.push_back(mk(K_BLT, 0, 0, 0));
        dir_q.push_back(mk(K_BR, 0, 30, 0));

        cur = next_rec();
        for (int c = 0; c < 800; c++) begin
            rst = cur.rst || (dir_q.size() == 0 && $urandom_range(0, 59) == 0);
            cycle(cur, rst, stl);
            if (rst) begin
                cur.rst = 1'b0;
                cur.bt  = 1'b0;
            end else if (stl) begin
                cur.bt = 1'b0;
            end else begin
                cur = next_rec();
            end
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
        end
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
